router_output_allocator: RTL and testbench
==========================================

// Module: router_output_allocator
// PURPOSE
//  Per-output wormhole switch allocator with downstream credit tracking for the NoC router.
//  One instance sits on each router output port: input FIFOs raise requests, the block picks one
//  input round-robin, and holds that input until its tail flit has gone.
//  It gates every grant on available downstream credits. Grants double as FIFO pops and crossbar selects.
// PARAMETERS
//  NUM_INPUTS         5  number of requesting input ports (0 = local injection port)
//  FLIT_BUFFER_DEPTH  4  downstream buffer depth; initial and maximum credit count
//  CREDIT_WIDTH       $clog2(FLIT_BUFFER_DEPTH+1)  width of the credit counter
// PORTS
//  clk_noc         in   1               NoC clock
//  rst_n           in   1               asynchronous active-low reset
//  req             in   NUM_INPUTS      req[i]: input i head flit is valid and routed to this output
//  req_is_tail     in   NUM_INPUTS      req_is_tail[i]: input i head flit is a tail flit
//  disable_turns   in   NUM_INPUTS      disable_turns[i]=1 masks input i permanently (quasi-static)
//  credit_in       in   1               one credit returned by the downstream buffer
//  grant           out  NUM_INPUTS      one-hot or zero; grant[i] pops input i and selects it this cycle
//  send_out        out  1               |grant; flit leaves on this output this cycle
//  is_tail_out     out  1               tail flag of the granted flit
//  locked          out  1               1 while in LOCKED state (a packet is mid-flight)
//  credit_count    out  CREDIT_WIDTH    current downstream credits
//  credit_err      out  1               sticky; credit_in received with counter at FLIT_BUFFER_DEPTH
//  stat_pkt_count  out  16              tail flits sent, wraps (ALLOC_STATS_EN only, else 0)
//  stat_stall_cyc  out  16              cycles with an eligible request but credit_count==0, saturating
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - state=IDLE; rr_ptr=0; credit_count=FLIT_BUFFER_DEPTH; credit_err=0; stats=0.
//   - Outputs grant, send_out and is_tail_out read 0 while reset is asserted.
//  Eligibility: elig = req & ~disable_turns; there is no grant if credit_count==0.
//  grant, send_out and is_tail_out are combinational from the registered state and current inputs (0-cycle latency).
//  All state updates happen on the rising edge of clk_noc.
//  IDLE:
//   - Grant the first elig bit scanning rr_ptr, rr_ptr+1, ... mod NUM_INPUTS.
//   - If the granted flit is a tail: stay IDLE and set rr_ptr = winner+1 (mod NUM_INPUTS).
//   - Otherwise: move to LOCKED and set lock_idx = winner.
//  LOCKED:
//   - grant[lock_idx] = req[lock_idx] & (credit_count>0). All other inputs are blocked.
//   - disable_turns is ignored for the locked input.
//   - A granted tail returns the block to IDLE and sets rr_ptr = lock_idx+1.
//   - A bubble (req[lock_idx]=0) holds the lock with no grant.
//  Credits:
//   - send_out alone: credit_count-1.
//   - credit_in alone: credit_count+1.
//   - send_out and credit_in together: credit_count unchanged.
//   - credit_in at FLIT_BUFFER_DEPTH with no send: count holds and credit_err is set.
//   - Underflow is impossible by construction.
//  Single-flit packets (head = tail) never enter LOCKED.
//  NUM_INPUTS=1 degenerates to credit-gated pass-through.
//  Reset mid-packet: the lock is dropped and credits are restored. The upstream/downstream buffers must be reset together.
// CONFIGURATION
//  ALLOC_STATS_EN defined:
//   - stat_pkt_count increments on every send_out&is_tail_out, wrapping at 2^16.
//   - stat_stall_cyc increments when the block is IDLE with |elig=1, or LOCKED with req[lock_idx]=1,
//     while credit_count==0. It saturates at 16'hFFFF.
//  ALLOC_STATS_EN undefined: both stat outputs are tied to 0, no registers are built, and the ports remain.
// TESTING
//  1. Reset with req=5'b00000 -> grant=0, credit_count=4, locked=0, credit_err=0.
//  2. req=5'b10110 held, all tails, credit_in every cycle -> grants in order input 1, 2, 4, 1.
//  3. In0 sends a 3-flit packet while in3 requests continuously -> grant=in0 for 3 cycles, locked=1 for cycles 1-2, then in3 is granted.
//  4. No credit_in, in2 streams non-tail flits -> 4 grants, then credit_count=0 and grant=0.
//     Then one credit_in -> exactly one further grant.
//  5. Simultaneous send and credit_in at count=2 -> count stays 2.
//     credit_in at count=4 -> credit_err=1 and stays 1 until reset.
//  6. disable_turns=5'b00010, req=5'b00010 -> no grant.
//     Reset while LOCKED on in4 -> next cycle locked=0 and credit_count=4.
//     With ALLOC_STATS_EN: 3 stalled cycles -> stat_stall_cyc=3.

Source files
------------

// File: rtl/router_output_allocator_if.sv
// Request/grant/credit bundle between input FIFOs, crossbar and one
// router output allocator. slave = allocator side, master = environment.
interface router_output_allocator_if #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
);
    logic [NUM_INPUTS-1:0]   req;
    logic [NUM_INPUTS-1:0]   req_is_tail;
    logic [NUM_INPUTS-1:0]   disable_turns;
    logic                    credit_in;
    logic [NUM_INPUTS-1:0]   grant;
    logic                    send_out;
    logic                    is_tail_out;
    logic                    locked;
    logic [CREDIT_WIDTH-1:0] credit_count;
    logic                    credit_err;
    logic [15:0]             stat_pkt_count;
    logic [15:0]             stat_stall_cyc;

    modport slave (
        input  req, req_is_tail, disable_turns, credit_in,
        output grant, send_out, is_tail_out, locked,
        output credit_count, credit_err,
        output stat_pkt_count, stat_stall_cyc
    );

    modport master (
        output req, req_is_tail, disable_turns, credit_in,
        input  grant, send_out, is_tail_out, locked,
        input  credit_count, credit_err,
        input  stat_pkt_count, stat_stall_cyc
    );
endinterface

// File: rtl/router_output_allocator.sv
// Per-output wormhole switch allocator with round-robin arbitration and
// downstream credit tracking. Optional statistics: define ALLOC_STATS_EN.
module router_output_allocator #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input logic                      clk_noc,
    input logic                      rst_n,
    router_output_allocator_if.slave bus
);
    localparam int IDXW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]         lock_idx_q, lock_idx_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    err_q, err_d;

    logic [NUM_INPUTS-1:0] elig;
    logic [NUM_INPUTS-1:0] grant_c;
    logic [IDXW-1:0]       win;
    logic                  found;
    logic                  has_credit;
    logic                  tail_sel;
    logic                  send;
    logic                  stall;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        if (int'(i) >= NUM_INPUTS - 1) return '0;
        return i + 1'b1;
    endfunction

    assign elig       = bus.req & ~bus.disable_turns;
    assign has_credit = (credit_q != '0);

    // First eligible input at or after rr_ptr, wrapping modulo NUM_INPUTS.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = IDXW'(idx);
            end
        end
    end

    always_comb begin
        grant_c  = '0;
        tail_sel = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                tail_sel = bus.req_is_tail[win];
                stall    = (|elig) && !has_credit;
                if (found && has_credit) grant_c[win] = 1'b1;
            end
            LOCKED: begin
                tail_sel = bus.req_is_tail[lock_idx_q];
                stall    = bus.req[lock_idx_q] && !has_credit;
                if (bus.req[lock_idx_q] && has_credit) grant_c[lock_idx_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are forced quiet while reset is held.
    assign send            = (|grant_c) && rst_n;
    assign bus.grant       = rst_n ? grant_c : '0;
    assign bus.send_out    = send;
    assign bus.is_tail_out = send && tail_sel;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (send) begin
            case (state_q)
                IDLE: begin
                    if (tail_sel) begin
                        rr_ptr_d = next_idx(win);
                    end else begin
                        state_d    = LOCKED;
                        lock_idx_d = win;
                    end
                end
                LOCKED: begin
                    if (tail_sel) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(lock_idx_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        case ({send, bus.credit_in})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CRED_MAX) err_d = 1'b1;
                else credit_d = credit_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            credit_q   <= CRED_MAX;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
        end
    end

    assign bus.locked       = (state_q == LOCKED);
    assign bus.credit_count = credit_q;
    assign bus.credit_err   = err_q;

`ifdef ALLOC_STATS_EN
    logic [15:0] pkt_q, pkt_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        pkt_d   = pkt_q;
        stall_d = stall_q;
        if (send && tail_sel) pkt_d = pkt_q + 16'd1;
        if (stall && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q   <= '0;
            stall_q <= '0;
        end else begin
            pkt_q   <= pkt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.stat_pkt_count = pkt_q;
    assign bus.stat_stall_cyc = stall_q;
`else
    logic unused_stall;
    assign unused_stall       = stall;
    assign bus.stat_pkt_count = '0;
    assign bus.stat_stall_cyc = '0;
`endif
endmodule

// File: tb/tb_router_output_allocator.sv
// Directed self-checking bench for router_output_allocator.
// Inputs change 1ns after a rising edge; outputs are checked before the next one.
module tb_router_output_allocator;
    logic clk_noc;
    logic rst_n;
    int   checks;
    int   failures;

    router_output_allocator_if #(.NUM_INPUTS(5), .FLIT_BUFFER_DEPTH(4)) bus ();

    router_output_allocator #(
        .NUM_INPUTS(5),
        .FLIT_BUFFER_DEPTH(4)
    ) dut (
        .clk_noc(clk_noc),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk_noc = 1'b0;
    always #5 clk_noc = ~clk_noc;

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic do_reset();
        bus.req           = '0;
        bus.req_is_tail   = '0;
        bus.disable_turns = '0;
        bus.credit_in     = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.req           = 5'b11111;
        bus.req_is_tail   = 5'b11111;
        bus.disable_turns = '0;
        bus.credit_in     = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.grant !== 5'b0) begin
            failures++;
            $display("FAIL rst_grant_held got=%b exp=%b", bus.grant, 5'b0);
        end
        checks++;
        if (bus.send_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_send got=%b exp=0", bus.send_out);
        end
        bus.req = '0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 5'b0) begin
            failures++;
            $display("FAIL rst_grant got=%b exp=%b", bus.grant, 5'b0);
        end
        checks++;
        if (bus.credit_count !== 3'd4) begin
            failures++;
            $display("FAIL rst_credit got=%0d exp=4", bus.credit_count);
        end
        checks++;
        if (bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL rst_locked got=%b exp=0", bus.locked);
        end
        checks++;
        if (bus.credit_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_err got=%b exp=0", bus.credit_err);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g [4];
        exp_g[0] = 5'b00010;
        exp_g[1] = 5'b00100;
        exp_g[2] = 5'b10000;
        exp_g[3] = 5'b00010;
        do_reset();
        bus.req         = 5'b10110;
        bus.req_is_tail = 5'b11111;
        bus.credit_in   = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.grant !== exp_g[i]) begin
                failures++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", i, bus.grant, exp_g[i]);
            end
            checks++;
            if (bus.is_tail_out !== 1'b1) begin
                failures++;
                $display("FAIL rr_tail[%0d] got=%b exp=1", i, bus.is_tail_out);
            end
            tick();
        end
        checks++;
        if (bus.credit_count !== 3'd4 || bus.credit_err !== 1'b0) begin
            failures++;
            $display("FAIL rr_credit got=%0d/%b exp=4/0", bus.credit_count, bus.credit_err);
        end
    endtask

    task automatic test_wormhole();
        do_reset();
        bus.req         = 5'b01001;
        bus.req_is_tail = 5'b01000;
        bus.credit_in   = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 5'b00001 || bus.locked !== 1'b0 || bus.is_tail_out !== 1'b0) begin
            failures++;
            $display("FAIL wh_head got=%b/%b/%b exp=00001/0/0", bus.grant, bus.locked, bus.is_tail_out);
        end
        tick();
        checks++;
        if (bus.grant !== 5'b00001 || bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL wh_body got=%b/%b exp=00001/1", bus.grant, bus.locked);
        end
        tick();
        bus.req = 5'b01000;
        #1;
        checks++;
        if (bus.grant !== 5'b00000 || bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL wh_bubble got=%b/%b exp=00000/1", bus.grant, bus.locked);
        end
        tick();
        bus.req         = 5'b01001;
        bus.req_is_tail = 5'b01001;
        #1;
        checks++;
        if (bus.grant !== 5'b00001 || bus.locked !== 1'b1 || bus.is_tail_out !== 1'b1) begin
            failures++;
            $display("FAIL wh_tail got=%b/%b/%b exp=00001/1/1", bus.grant, bus.locked, bus.is_tail_out);
        end
        tick();
        bus.req = 5'b01000;
        #1;
        checks++;
        if (bus.grant !== 5'b01000 || bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL wh_next got=%b/%b exp=01000/0", bus.grant, bus.locked);
        end
        tick();
        checks++;
        if (bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL wh_single_flit got=%b exp=0", bus.locked);
        end
    endtask

    task automatic test_credits();
        do_reset();
        bus.req         = 5'b00100;
        bus.req_is_tail = 5'b00000;
        bus.credit_in   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.grant !== 5'b00100 || bus.credit_count !== 3'(4 - i)) begin
                failures++;
                $display("FAIL cr_drain[%0d] got=%b/%0d exp=00100/%0d", i, bus.grant, bus.credit_count, 4 - i);
            end
            tick();
        end
        checks++;
        if (bus.grant !== 5'b0 || bus.credit_count !== 3'd0 || bus.send_out !== 1'b0) begin
            failures++;
            $display("FAIL cr_empty got=%b/%0d/%b exp=00000/0/0", bus.grant, bus.credit_count, bus.send_out);
        end
        bus.credit_in = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 5'b0) begin
            failures++;
            $display("FAIL cr_return_same got=%b exp=00000", bus.grant);
        end
        tick();
        bus.credit_in = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 5'b00100 || bus.credit_count !== 3'd1) begin
            failures++;
            $display("FAIL cr_one_more got=%b/%0d exp=00100/1", bus.grant, bus.credit_count);
        end
        tick();
        checks++;
        if (bus.grant !== 5'b0 || bus.credit_count !== 3'd0) begin
            failures++;
            $display("FAIL cr_empty2 got=%b/%0d exp=00000/0", bus.grant, bus.credit_count);
        end
        bus.req       = 5'b0;
        bus.credit_in = 1'b1;
        tick();
        tick();
        bus.req = 5'b00100;
        #1;
        checks++;
        if (bus.grant !== 5'b00100 || bus.credit_count !== 3'd2) begin
            failures++;
            $display("FAIL cr_simul_pre got=%b/%0d exp=00100/2", bus.grant, bus.credit_count);
        end
        tick();
        checks++;
        if (bus.credit_count !== 3'd2) begin
            failures++;
            $display("FAIL cr_simul got=%0d exp=2", bus.credit_count);
        end
        bus.req = 5'b0;
        tick();
        tick();
        checks++;
        if (bus.credit_count !== 3'd4 || bus.credit_err !== 1'b0) begin
            failures++;
            $display("FAIL cr_refill got=%0d/%b exp=4/0", bus.credit_count, bus.credit_err);
        end
        tick();
        bus.credit_in = 1'b0;
        checks++;
        if (bus.credit_count !== 3'd4 || bus.credit_err !== 1'b1) begin
            failures++;
            $display("FAIL cr_overflow got=%0d/%b exp=4/1", bus.credit_count, bus.credit_err);
        end
        tick();
        tick();
        checks++;
        if (bus.credit_err !== 1'b1) begin
            failures++;
            $display("FAIL cr_err_sticky got=%b exp=1", bus.credit_err);
        end
    endtask

    task automatic test_disable();
        do_reset();
        bus.disable_turns = 5'b00010;
        bus.req           = 5'b00010;
        bus.req_is_tail   = 5'b00000;
        #1;
        checks++;
        if (bus.grant !== 5'b0 || bus.send_out !== 1'b0) begin
            failures++;
            $display("FAIL dis_mask got=%b/%b exp=00000/0", bus.grant, bus.send_out);
        end
        bus.req = 5'b00110;
        #1;
        checks++;
        if (bus.grant !== 5'b00100) begin
            failures++;
            $display("FAIL dis_skip got=%b exp=00100", bus.grant);
        end
        do_reset();
        bus.req = 5'b00010;
        #1;
        tick();
        bus.disable_turns = 5'b00010;
        #1;
        checks++;
        if (bus.grant !== 5'b00010 || bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL dis_locked_ignored got=%b/%b exp=00010/1", bus.grant, bus.locked);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.req         = 5'b10000;
        bus.req_is_tail = 5'b00000;
        tick();
        tick();
        checks++;
        if (bus.locked !== 1'b1 || bus.credit_count !== 3'd2) begin
            failures++;
            $display("FAIL mid_pre got=%b/%0d exp=1/2", bus.locked, bus.credit_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.locked !== 1'b0 || bus.credit_count !== 3'd4 || bus.grant !== 5'b0) begin
            failures++;
            $display("FAIL mid_async got=%b/%0d/%b exp=0/4/00000", bus.locked, bus.credit_count, bus.grant);
        end
        bus.req = 5'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.locked !== 1'b0 || bus.credit_count !== 3'd4) begin
            failures++;
            $display("FAIL mid_after got=%b/%0d exp=0/4", bus.locked, bus.credit_count);
        end
    endtask

    task automatic test_stats();
        do_reset();
        bus.req         = 5'b00001;
        bus.req_is_tail = 5'b00001;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 3; i++) tick();
`ifdef ALLOC_STATS_EN
        checks++;
        if (bus.stat_pkt_count !== 16'd4) begin
            failures++;
            $display("FAIL st_pkt got=%0d exp=4", bus.stat_pkt_count);
        end
        checks++;
        if (bus.stat_stall_cyc !== 16'd3) begin
            failures++;
            $display("FAIL st_stall got=%0d exp=3", bus.stat_stall_cyc);
        end
`else
        checks++;
        if (bus.stat_pkt_count !== 16'd0 || bus.stat_stall_cyc !== 16'd0) begin
            failures++;
            $display("FAIL st_tied got=%0d/%0d exp=0/0", bus.stat_pkt_count, bus.stat_stall_cyc);
        end
`endif
        checks++;
        if (bus.credit_count !== 3'd0 || bus.grant !== 5'b0) begin
            failures++;
            $display("FAIL st_credit got=%0d/%b exp=0/00000", bus.credit_count, bus.grant);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credits();
        test_disable();
        test_reset_mid_packet();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
